// File: rtl/video_timing_gen_if.sv
// video_if: registered pixel/sync bus from the timing generator to the TMDS encoder
interface video_if;
  logic [7:0]  red;
  logic [7:0]  green;
  logic [7:0]  blue;
  logic        hsync;
  logic        vsync;
  logic        de;
  logic [3:0]  ctrl;
  logic [11:0] x;
  logic [11:0] y;
  logic        frame_start;
  modport master (output red, green, blue, hsync, vsync, de, ctrl, x, y, frame_start);
  modport slave  (input  red, green, blue, hsync, vsync, de, ctrl, x, y, frame_start);
endinterface

// File: rtl/video_timing_gen.sv
// video_timing_gen: raster timing plus selectable test pattern, all outputs registered and aligned
module video_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0
) (
  input  logic        i_pixclk,
  input  logic        i_reset_n,
  input  logic [1:0]  i_pattern,
  input  logic [23:0] i_solid_rgb,
  video_if.master     vid_o
);
  localparam logic [11:0] HA  = 12'(H_ACTIVE);
  localparam logic [11:0] HS0 = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS1 = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] HT1 = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [11:0] VA  = 12'(V_ACTIVE);
  localparam logic [11:0] VS0 = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS1 = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [11:0] VT1 = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [11:0] BW1 = 12'(H_ACTIVE / 8 - 1);
  logic [11:0] h_q, h_d, v_q, v_d, bar_cnt_q, bar_cnt_d, x_q, y_q;
  logic [2:0]  bar_idx_q, bar_idx_d;
  logic [7:0]  frame_q, frame_d;
  logic [1:0]  pat_q, pat_d;
  logic [23:0] bar_rgb, rgb_d, rgb_q;
  logic        h_wrap, v_wrap, fs, de, hs_d, vs_d;
  logic        de_q, hs_q, vs_q, fs_q;
  // Next raster position, frame count, frame-latched pattern and bar tracking (bar counter avoids a divider)
  always_comb begin
    h_wrap    = h_q == HT1;
    v_wrap    = v_q == VT1;
    h_d       = h_wrap ? '0 : h_q + 12'd1;
    v_d       = h_wrap ? (v_wrap ? '0 : v_q + 12'd1) : v_q;
    frame_d   = (h_wrap && v_wrap) ? frame_q + 8'd1 : frame_q;
    fs        = h_q == '0 && v_q == '0;
    pat_d     = fs ? i_pattern : pat_q;
    bar_cnt_d = (h_wrap || bar_cnt_q == BW1) ? '0 : bar_cnt_q + 12'd1;
    bar_idx_d = h_wrap ? '0 : (bar_cnt_q == BW1 ? bar_idx_q + 3'd1 : bar_idx_q);
  end
  // Decode of the position held now; pixel (0,0) already uses the newly latched pattern
  always_comb begin
    de      = h_q < HA && v_q < VA;
    hs_d    = (h_q >= HS0 && h_q < HS1) ? HSYNC_POL : ~HSYNC_POL;
    vs_d    = (v_q >= VS0 && v_q < VS1) ? VSYNC_POL : ~VSYNC_POL;
    bar_rgb = {{8{~bar_idx_q[1]}}, {8{~bar_idx_q[2]}}, {8{~bar_idx_q[0]}}};
    rgb_d   = !de ? '0 :
              pat_d == 2'd0 ? bar_rgb :
              pat_d == 2'd1 ? {h_q[7:0], v_q[7:0], frame_q} :
              pat_d == 2'd2 ? {24{~(h_q[5] ^ v_q[5])}} : i_solid_rgb;
  end
  // Counters advance and every output registers on the same edge
  always_ff @(posedge i_pixclk) begin
    if (!i_reset_n) begin
      h_q       <= '0;
      v_q       <= '0;
      bar_cnt_q <= '0;
      bar_idx_q <= '0;
      frame_q   <= '0;
      pat_q     <= '0;
      rgb_q     <= '0;
      de_q      <= 1'b0;
      hs_q      <= ~HSYNC_POL;
      vs_q      <= ~VSYNC_POL;
      fs_q      <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
    end else begin
      h_q       <= h_d;
      v_q       <= v_d;
      bar_cnt_q <= bar_cnt_d;
      bar_idx_q <= bar_idx_d;
      frame_q   <= frame_d;
      pat_q     <= pat_d;
      rgb_q     <= rgb_d;
      de_q      <= de;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      fs_q      <= fs;
      x_q       <= de ? h_q : '0;
      y_q       <= de ? v_q : '0;
    end
  end
  assign vid_o.red         = rgb_q[23:16];
  assign vid_o.green       = rgb_q[15:8];
  assign vid_o.blue        = rgb_q[7:0];
  assign vid_o.de          = de_q;
  assign vid_o.hsync       = hs_q;
  assign vid_o.vsync       = vs_q;
  assign vid_o.frame_start = fs_q;
  assign vid_o.x           = x_q;
  assign vid_o.y           = y_q;
  assign vid_o.ctrl        = 4'b0000;
endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: scoreboard bench for video_timing_gen on a reduced raster
module tb_video_timing_gen;
  localparam int HA = 64, HFP = 4, HS = 8, HB = 4, HT = HA + HFP + HS + HB;
  localparam int VA = 40, VFP = 2, VS = 2, VB = 3, VT = VA + VFP + VS + VB;
  typedef struct packed {
    logic        de, hs, vs, fs;
    logic [11:0] x, y;
    logic [23:0] rgb;
    logic [3:0]  ctrl;
  } vout_t;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  pat = 2'd0;
  logic [23:0] solid = 24'd0;
  vout_t       sb_q[$];
  vout_t       got, exp_v;
  int          checks = 0, fails = 0;
  int          px = 0, py = 0;
  logic [7:0]  pf = 8'd0;
  logic [1:0]  ppat = 2'd0;
  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
  video_if vif();
  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VB),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
  ) dut (
    .i_pixclk(clk), .i_reset_n(rst_n), .i_pattern(pat), .i_solid_rgb(solid), .vid_o(vif)
  );
  always #5 clk = ~clk;
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, fails=%0d", fails);
    $fatal(1);
  end
  function automatic vout_t model();
    vout_t v;
    logic [1:0] p;
    logic [11:0] x12, y12;
    v = '0;
    if (!rst_n) begin
      v.hs = 1'b1;
      v.vs = 1'b1;
      return v;
    end
    v.de = px < HA && py < VA;
    v.hs = !(px >= HA + HFP && px < HA + HFP + HS);
    v.vs = !(py >= VA + VFP && py < VA + VFP + VS);
    v.fs = px == 0 && py == 0;
    p = v.fs ? pat : ppat;
    x12 = 12'(px);
    y12 = 12'(py);
    if (v.de) begin
      v.x = x12;
      v.y = y12;
      case (p)
        2'd0: v.rgb = bars[px / (HA / 8)];
        2'd1: v.rgb = {x12[7:0], y12[7:0], pf};
        2'd2: v.rgb = ((px / 32 + py / 32) % 2 == 1) ? 24'h000000 : 24'hFFFFFF;
        default: v.rgb = solid;
      endcase
    end
    return v;
  endfunction
  function automatic vout_t sample();
    return {vif.de, vif.hsync, vif.vsync, vif.frame_start, vif.x, vif.y,
            vif.red, vif.green, vif.blue, vif.ctrl};
  endfunction
  task automatic cyc(input bit chk);
    if (chk) sb_q.push_back(model());
    @(posedge clk);
    if (!rst_n) begin
      px = 0; py = 0; pf = 8'd0; ppat = 2'd0;
    end else begin
      if (px == 0 && py == 0) ppat = pat;
      if (px == HT - 1) begin
        px = 0;
        if (py == VT - 1) begin py = 0; pf++; end else py++;
      end else px++;
    end
    #1;
  endtask
  task automatic goto(input int x, input int y, input int f);
    for (int i = 0; i < 40000 && !(px == x && py == y && (f < 0 || pf == 8'(f))); i++) cyc(1'b0);
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1);
      exp_v = sb_q.pop_front(); got = sample(); checks++;
      if (got !== exp_v) begin fails++; $display("FAIL reset cycle %0d: got %h want %h", i, got, exp_v); end
    end
    checks++;
    if (vif.de !== 1'b0 || vif.hsync !== 1'b1 || vif.vsync !== 1'b1 || vif.ctrl !== 4'h0 ||
        {vif.red, vif.green, vif.blue} !== 24'h0) begin
      fails++;
      $display("FAIL reset_values: de=%b hs=%b vs=%b rgb=%h ctrl=%h want 0 1 1 000000 0",
               vif.de, vif.hsync, vif.vsync, {vif.red, vif.green, vif.blue}, vif.ctrl);
    end
  endtask
  task automatic test_frame_timing();
    int de_cnt = 0, hs_cnt = 0, hs_start = -1, de_rise2 = -1, vs_cnt = 0, vs_start = -1, fs2 = -1;
    logic prev_de = 1'b0;
    int cx, cy;
    pat = 2'd0;
    rst_n = 1'b1;
    for (int k = 0; k <= HT * VT; k++) begin
      cx = px; cy = py;
      cyc(1'b1);
      exp_v = sb_q.pop_front(); got = sample(); checks++;
      if (got !== exp_v) begin fails++; $display("FAIL raster (%0d,%0d): got %h want %h", cx, cy, got, exp_v); end
      if (k < HT) begin
        de_cnt += int'(got.de);
        if (!got.hs) begin hs_cnt++; if (hs_start < 0) hs_start = k; end
      end
      if (k > 0 && got.de && !prev_de && de_rise2 < 0) de_rise2 = k;
      if (k < HT * VT && !got.vs) begin vs_cnt++; if (vs_start < 0) vs_start = k; end
      if (k > 0 && got.fs && fs2 < 0) fs2 = k;
      prev_de = got.de;
    end
    checks++; if (de_cnt != HA) begin fails++; $display("FAIL de_width: got %0d want %0d", de_cnt, HA); end
    checks++; if (hs_start != HA + HFP) begin fails++; $display("FAIL hsync_start: got %0d want %0d", hs_start, HA + HFP); end
    checks++; if (hs_cnt != HS) begin fails++; $display("FAIL hsync_width: got %0d want %0d", hs_cnt, HS); end
    checks++; if (de_rise2 != HT) begin fails++; $display("FAIL line_period: got %0d want %0d", de_rise2, HT); end
    checks++; if (vs_cnt != VS * HT) begin fails++; $display("FAIL vsync_width: got %0d want %0d", vs_cnt, VS * HT); end
    checks++; if (vs_start != (VA + VFP) * HT) begin fails++; $display("FAIL vsync_start: got %0d want %0d", vs_start, (VA + VFP) * HT); end
    checks++; if (fs2 != HT * VT) begin fails++; $display("FAIL frame_period: got %0d want %0d", fs2, HT * VT); end
  endtask
  task automatic test_colour_bars();
    int xs [4] = '{0, 8, 63, 64};
    logic [23:0] cs [4] = '{24'hFFFFFF, 24'hFFFF00, 24'h000000, 24'h000000};
    int cx;
    pat = 2'd0;
    goto(0, 5, -1);
    for (int k = 0; k < HT; k++) begin
      cx = px;
      cyc(1'b1);
      exp_v = sb_q.pop_front(); got = sample(); checks++;
      if (got !== exp_v) begin fails++; $display("FAIL bars x=%0d: got %h want %h", cx, got, exp_v); end
      for (int j = 0; j < 4; j++) if (cx == xs[j]) begin
        checks++;
        if (got.rgb !== cs[j]) begin fails++; $display("FAIL bar_colour x=%0d: got %h want %h", cx, got.rgb, cs[j]); end
      end
    end
  endtask
  task automatic test_patterns();
    int cx, cy;
    for (int p = 1; p < 4; p++) begin
      goto(0, 0, -1);
      pat = 2'(p);
      for (int k = 0; k < HT * VT; k++) begin
        cx = px; cy = py;
        if (p == 3) solid = 24'($urandom);
        cyc(1'b1);
        exp_v = sb_q.pop_front(); got = sample(); checks++;
        if (got !== exp_v) begin fails++; $display("FAIL pattern%0d (%0d,%0d): got %h want %h", p, cx, cy, got, exp_v); end
        if (p == 2 && cx == 32 && (cy == 0 || cy == 32)) begin
          checks++;
          if (got.rgb !== (cy == 0 ? 24'h000000 : 24'hFFFFFF)) begin
            fails++; $display("FAIL checker (32,%0d): got %h", cy, got.rgb);
          end
        end
      end
    end
  endtask
  task automatic test_gradient();
    pat = 2'd1;
    rst_n = 1'b0;
    cyc(1'b0);
    rst_n = 1'b1;
    goto(10, 20, 3);
    cyc(1'b1);
    exp_v = sb_q.pop_front(); got = sample(); checks++;
    if (got !== exp_v) begin fails++; $display("FAIL gradient_sb: got %h want %h", got, exp_v); end
    checks++;
    if (got.rgb !== 24'h0A1403) begin fails++; $display("FAIL gradient (10,20) frame 3: got %h want 0a1403", got.rgb); end
  endtask
  task automatic test_pattern_switch();
    pat = 2'd0;
    goto(0, 0, -1);
    goto(0, 10, -1);
    pat = 2'd2;
    goto(8, 20, -1);
    cyc(1'b1);
    exp_v = sb_q.pop_front(); got = sample(); checks++;
    if (got !== exp_v || got.rgb !== 24'hFFFF00) begin fails++; $display("FAIL switch_same_frame: got %h want %h", got, exp_v); end
    goto(0, 0, -1);
    cyc(1'b1);
    exp_v = sb_q.pop_front(); got = sample(); checks++;
    if (got !== exp_v || got.rgb !== 24'hFFFFFF) begin fails++; $display("FAIL switch_next_0: got %h want %h", got, exp_v); end
    goto(32, 0, -1);
    cyc(1'b1);
    exp_v = sb_q.pop_front(); got = sample(); checks++;
    if (got !== exp_v || got.rgb !== 24'h000000) begin fails++; $display("FAIL switch_next_32: got %h want %h", got, exp_v); end
  endtask
  task automatic test_reset_mid_frame();
    goto(30, 20, -1);
    cyc(1'b1);
    exp_v = sb_q.pop_front(); got = sample(); checks++;
    if (got !== exp_v) begin fails++; $display("FAIL mid_before: got %h want %h", got, exp_v); end
    rst_n = 1'b0;
    cyc(1'b1);
    exp_v = sb_q.pop_front(); got = sample(); checks++;
    if (got !== exp_v || got.de !== 1'b0 || got.hs !== 1'b1 || got.x !== 12'd0) begin
      fails++; $display("FAIL mid_reset: got %h want %h", got, exp_v);
    end
    rst_n = 1'b1;
    for (int k = 0; k < HT; k++) begin
      cyc(1'b1);
      exp_v = sb_q.pop_front(); got = sample(); checks++;
      if (got !== exp_v) begin fails++; $display("FAIL mid_restart k=%0d: got %h want %h", k, got, exp_v); end
      if (k == 0) begin
        checks++;
        if (got.fs !== 1'b1 || got.x !== 12'd0 || got.y !== 12'd0 || got.de !== 1'b1) begin
          fails++; $display("FAIL mid_first_pixel: fs=%b x=%0d y=%0d de=%b want 1 0 0 1", got.fs, got.x, got.y, got.de);
        end
      end
    end
  endtask
  initial begin
    test_reset();
    test_frame_timing();
    test_colour_bars();
    test_patterns();
    test_gradient();
    test_pattern_switch();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
